kanagawa_hal_multi_channel_rv_fifo: RTL and testbench

- CHANNELS independent ready/valid FIFOs in one block, single clock domain, each with its own storage, occupancy and status flags.
- Successor to the single-channel ready/valid FIFO wrapper. Adds:
  - arbitrary (non-power-of-2) depth;
  - an optional registered-output mode;
  - per-channel synchronous flush;
  - an almost-empty flag.
- Sits between pipeline stages that multiplex several logical streams.

---
 rtl/kanagawa_hal_multi_channel_rv_fifo_pkg.sv | 17 +
 rtl/kanagawa_hal_multi_channel_rv_fifo_if.sv | 39 +++
 rtl/kanagawa_hal_rv_fifo_channel.sv | 136 +++++++++++++
 rtl/kanagawa_hal_multi_channel_rv_fifo.sv | 68 ++++++
 tb/tb_kanagawa_hal_multi_channel_rv_fifo.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/kanagawa_hal_multi_channel_rv_fifo_pkg.sv
// kanagawa_hal_fifo_pkg
//    Sizing helpers shared by the multi-channel ready/valid FIFO, its
//    per-channel sub-module and the bus interface.
//    No ports; this file holds functions only.
package kanagawa_hal_fifo_pkg;

   // The occupancy counter must represent 0..depth inclusive.
   function automatic int usedw_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   // A storage pointer always gets at least one bit, even for a single-entry store.
   function automatic int ptr_width(input int depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/kanagawa_hal_multi_channel_rv_fifo_if.sv
// kanagawa_hal_multi_channel_rv_fifo_if
//    Bundles the per-channel write side, read side, flush and status buses
//    of the multi-channel FIFO. Channel c occupies bit c of each flag bus,
//    bits [c*WIDTH +: WIDTH] of the data buses and bits [c*UW +: UW] of usedw.
//    Modports:
//       master - the stream producer/consumer (drives valid/data/flush/ready-to-pop)
//       slave  - the FIFO block
interface kanagawa_hal_multi_channel_rv_fifo_if
   import kanagawa_hal_fifo_pkg::*;
#(
   parameter int CHANNELS = 4,
   parameter int WIDTH    = 32,
   parameter int DEPTH    = 32
) ();
   localparam int UW = usedw_width(DEPTH);

   logic [CHANNELS-1:0]       input_valid;
   logic [CHANNELS-1:0]       input_ready;
   logic [CHANNELS*WIDTH-1:0] input_data;
   logic [CHANNELS*UW-1:0]    input_usedw;
   logic [CHANNELS-1:0]       input_almost_full;
   logic [CHANNELS-1:0]       flush;
   logic [CHANNELS-1:0]       output_valid;
   logic [CHANNELS-1:0]       output_ready;
   logic [CHANNELS*WIDTH-1:0] output_data;
   logic [CHANNELS-1:0]       output_almost_empty;

   modport master (
      output input_valid, input_data, flush, output_ready,
      input  input_ready, input_usedw, input_almost_full,
      input  output_valid, output_data, output_almost_empty
   );

   modport slave (
      input  input_valid, input_data, flush, output_ready,
      output input_ready, input_usedw, input_almost_full,
      output output_valid, output_data, output_almost_empty
   );
endinterface

// File: rtl/kanagawa_hal_rv_fifo_channel.sv
// kanagawa_hal_rv_fifo_channel
//    One ready/valid FIFO channel: storage array, wrap-by-compare pointers,
//    exact registered occupancy, almost-full/almost-empty flags, synchronous
//    flush and an optional registered output stage.
//    Ports:
//       clock, rst            - clock and synchronous active-high reset
//       flush                 - discard all contents (wins over write/pop)
//       input_valid/_ready/_data, input_usedw, input_almost_full - write side
//       output_valid/_ready/_data, output_almost_empty           - read side
module kanagawa_hal_rv_fifo_channel
   import kanagawa_hal_fifo_pkg::*;
#(
   parameter int DEPTH               = 32,
   parameter int WIDTH               = 32,
   parameter int ALMOSTFULL_ENTRIES  = 0,
   parameter int ALMOSTEMPTY_ENTRIES = 0,
   parameter int REGISTERED_OUTPUT   = 0
) (
   input  logic                          clock,
   input  logic                          rst,
   input  logic                          flush,
   input  logic                          input_valid,
   output logic                          input_ready,
   input  logic [WIDTH-1:0]              input_data,
   output logic [usedw_width(DEPTH)-1:0] input_usedw,
   output logic                          input_almost_full,
   output logic                          output_valid,
   input  logic                          output_ready,
   output logic [WIDTH-1:0]              output_data,
   output logic                          output_almost_empty
);
   localparam int UW = usedw_width(DEPTH);
   // With an output register one of the DEPTH entries lives in that register.
   localparam int SD = (REGISTERED_OUTPUT != 0) ? DEPTH - 1 : DEPTH;
   localparam int PW = ptr_width(SD);

   localparam logic [UW-1:0] DEPTH_U  = UW'(DEPTH);
   localparam logic [UW-1:0] AF_LEVEL = UW'(DEPTH - ALMOSTFULL_ENTRIES);
   localparam logic [UW-1:0] AE_LEVEL = UW'(ALMOSTEMPTY_ENTRIES);
   localparam logic [PW-1:0] LAST_PTR = PW'(SD - 1);

   logic [WIDTH-1:0] mem_q [SD];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [UW-1:0]    usedw_q, usedw_d;
   logic             wr_en;   // accepted write
   logic             pop;     // accepted pop at the output
   logic             st_rd;   // head entry leaves the storage array

   // Non-power-of-2 depth: wrap by explicit compare.
   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PW'(1);
   endfunction

   // Space freed by a same-cycle pop is deliberately not offered to the writer.
   assign input_ready = ~rst & (usedw_q < DEPTH_U);
   assign wr_en       = input_valid & input_ready & ~flush;
   assign pop         = output_valid & output_ready & ~flush;

   always_comb begin
      usedw_d  = usedw_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wr_en && !pop) begin
         usedw_d = usedw_q + UW'(1);
      end else if (!wr_en && pop) begin
         usedw_d = usedw_q - UW'(1);
      end
      if (wr_en) begin
         wr_ptr_d = next_ptr(wr_ptr_q);
      end
      if (st_rd) begin
         rd_ptr_d = next_ptr(rd_ptr_q);
      end
   end

   always_ff @(posedge clock) begin
      if (rst || flush) begin
         usedw_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         usedw_q  <= usedw_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage contents are never cleared; validity is tracked by usedw.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= input_data;
      end
   end

   assign input_usedw         = usedw_q;
   assign input_almost_full   = (usedw_q >= AF_LEVEL);
   assign output_almost_empty = (usedw_q <= AE_LEVEL);

   generate
      if (REGISTERED_OUTPUT == 0) begin : g_show_ahead
         assign output_valid = (usedw_q != '0);
         assign output_data  = mem_q[rd_ptr_q];
         assign st_rd        = pop;
      end else begin : g_reg_out
         logic             out_valid_q;
         logic [WIDTH-1:0] out_data_q;
         logic             st_nonempty;

         // usedw counts the output register too, so storage holds usedw - out_valid.
         assign st_nonempty = (usedw_q != UW'(out_valid_q));
         // Refill whenever the register is empty or being popped this edge.
         assign st_rd       = st_nonempty & (~out_valid_q | pop) & ~flush;

         always_ff @(posedge clock) begin
            if (rst || flush) begin
               out_valid_q <= 1'b0;
            end else if (st_rd) begin
               out_valid_q <= 1'b1;
            end else if (pop) begin
               out_valid_q <= 1'b0;
            end
         end

         always_ff @(posedge clock) begin
            if (st_rd) begin
               out_data_q <= mem_q[rd_ptr_q];
            end
         end

         assign output_valid = out_valid_q;
         assign output_data  = out_data_q;
      end
   endgenerate

endmodule

// File: rtl/kanagawa_hal_multi_channel_rv_fifo.sv
// kanagawa_hal_multi_channel_rv_fifo
//    CHANNELS independent ready/valid FIFOs sharing one clock. The top level
//    only slices the interface buses and instantiates one channel per stream.
//    Ports:
//       clock - single clock
//       rst   - synchronous active-high reset, discards all contents
//       bus   - slave modport carrying per-channel write/read/flush/status
module kanagawa_hal_multi_channel_rv_fifo
   import kanagawa_hal_fifo_pkg::*;
#(
   parameter int CHANNELS            = 4,
   parameter int DEPTH               = 32,
   parameter int WIDTH               = 32,
   parameter int ALMOSTFULL_ENTRIES  = 0,
   parameter int ALMOSTEMPTY_ENTRIES = 0,
   parameter int REGISTERED_OUTPUT   = 0,
   parameter int USE_LUTRAM          = 0
) (
   input logic                                 clock,
   input logic                                 rst,
   kanagawa_hal_multi_channel_rv_fifo_if.slave bus
);
   localparam int UW = usedw_width(DEPTH);

   // Elaboration-time parameter checks.
   if (ALMOSTFULL_ENTRIES >= DEPTH) begin : g_chk_af
      $error("ALMOSTFULL_ENTRIES must be less than DEPTH");
   end
   if (ALMOSTEMPTY_ENTRIES >= DEPTH) begin : g_chk_ae
      $error("ALMOSTEMPTY_ENTRIES must be less than DEPTH");
   end
   if (DEPTH < 2) begin : g_chk_depth
      $error("DEPTH must be at least 2");
   end
   if (CHANNELS < 1) begin : g_chk_channels
      $error("CHANNELS must be at least 1");
   end
   // Storage style is a placement hint only; reject nonsense values.
   if (USE_LUTRAM != 0 && USE_LUTRAM != 1) begin : g_chk_lutram
      $error("USE_LUTRAM must be 0 or 1");
   end

   generate
      for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
         kanagawa_hal_rv_fifo_channel #(
            .DEPTH               (DEPTH),
            .WIDTH               (WIDTH),
            .ALMOSTFULL_ENTRIES  (ALMOSTFULL_ENTRIES),
            .ALMOSTEMPTY_ENTRIES (ALMOSTEMPTY_ENTRIES),
            .REGISTERED_OUTPUT   (REGISTERED_OUTPUT)
         ) u_channel (
            .clock               (clock),
            .rst                 (rst),
            .flush               (bus.flush[gi]),
            .input_valid         (bus.input_valid[gi]),
            .input_ready         (bus.input_ready[gi]),
            .input_data          (bus.input_data[gi*WIDTH +: WIDTH]),
            .input_usedw         (bus.input_usedw[gi*UW +: UW]),
            .input_almost_full   (bus.input_almost_full[gi]),
            .output_valid        (bus.output_valid[gi]),
            .output_ready        (bus.output_ready[gi]),
            .output_data         (bus.output_data[gi*WIDTH +: WIDTH]),
            .output_almost_empty (bus.output_almost_empty[gi])
         );
      end
   endgenerate

endmodule

// File: tb/tb_kanagawa_hal_multi_channel_rv_fifo.sv
// Bench: four FIFO configurations driven by one shared stimulus stream,
// each compared every cycle against a queue-level reference model.
//    inst 0: DEPTH=5, show-ahead
//    inst 1: DEPTH=5, registered output, AF=1, AE=1
//    inst 2: DEPTH=8, show-ahead, AF=2, AE=1
//    inst 3: DEPTH=2, registered output (single storage slot)
module tb_kanagawa_hal_multi_channel_rv_fifo;
   localparam int NI   = 4;
   localparam int NC   = 2;
   localparam int MAXD = 16;
   localparam int P_DEPTH [NI] = '{5, 5, 8, 2};
   localparam int P_REG   [NI] = '{0, 1, 0, 1};
   localparam int P_AF    [NI] = '{0, 1, 2, 0};
   localparam int P_AE    [NI] = '{0, 1, 1, 0};

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  iv, fl, ordy;
   logic [15:0] idata;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   always #5 clk = ~clk;

   kanagawa_hal_multi_channel_rv_fifo_if #(.CHANNELS(2), .WIDTH(8), .DEPTH(5)) ifa ();
   kanagawa_hal_multi_channel_rv_fifo_if #(.CHANNELS(2), .WIDTH(8), .DEPTH(5)) ifb ();
   kanagawa_hal_multi_channel_rv_fifo_if #(.CHANNELS(2), .WIDTH(8), .DEPTH(8)) ifc ();
   kanagawa_hal_multi_channel_rv_fifo_if #(.CHANNELS(2), .WIDTH(8), .DEPTH(2)) ifd ();

   assign ifa.input_valid = iv;  assign ifa.input_data = idata;
   assign ifa.flush = fl;        assign ifa.output_ready = ordy;
   assign ifb.input_valid = iv;  assign ifb.input_data = idata;
   assign ifb.flush = fl;        assign ifb.output_ready = ordy;
   assign ifc.input_valid = iv;  assign ifc.input_data = idata;
   assign ifc.flush = fl;        assign ifc.output_ready = ordy;
   assign ifd.input_valid = iv;  assign ifd.input_data = idata;
   assign ifd.flush = fl;        assign ifd.output_ready = ordy;

   kanagawa_hal_multi_channel_rv_fifo #(
      .CHANNELS(2), .DEPTH(5), .WIDTH(8), .ALMOSTFULL_ENTRIES(0),
      .ALMOSTEMPTY_ENTRIES(0), .REGISTERED_OUTPUT(0), .USE_LUTRAM(0)
   ) dut_a (.clock(clk), .rst(rst), .bus(ifa));

   kanagawa_hal_multi_channel_rv_fifo #(
      .CHANNELS(2), .DEPTH(5), .WIDTH(8), .ALMOSTFULL_ENTRIES(1),
      .ALMOSTEMPTY_ENTRIES(1), .REGISTERED_OUTPUT(1), .USE_LUTRAM(1)
   ) dut_b (.clock(clk), .rst(rst), .bus(ifb));

   kanagawa_hal_multi_channel_rv_fifo #(
      .CHANNELS(2), .DEPTH(8), .WIDTH(8), .ALMOSTFULL_ENTRIES(2),
      .ALMOSTEMPTY_ENTRIES(1), .REGISTERED_OUTPUT(0), .USE_LUTRAM(0)
   ) dut_c (.clock(clk), .rst(rst), .bus(ifc));

   kanagawa_hal_multi_channel_rv_fifo #(
      .CHANNELS(2), .DEPTH(2), .WIDTH(8), .ALMOSTFULL_ENTRIES(0),
      .ALMOSTEMPTY_ENTRIES(0), .REGISTERED_OUTPUT(1), .USE_LUTRAM(0)
   ) dut_d (.clock(clk), .rst(rst), .bus(ifd));

   // ---------------- reference model ----------------
   // Per (instance, channel): a FIFO queue of entries still in storage and,
   // for registered-output configurations, a separate output slot.
   logic [7:0] mbuf  [NI*NC][MAXD];
   int         mhead [NI*NC];
   int         mcnt  [NI*NC];
   bit         mov   [NI*NC];
   logic [7:0] mod   [NI*NC];

   function automatic void q_push(int i, logic [7:0] d);
      mbuf[i][(mhead[i] + mcnt[i]) % MAXD] = d;
      mcnt[i]++;
   endfunction

   function automatic logic [7:0] q_pop(int i);
      logic [7:0] d;
      d        = mbuf[i][mhead[i]];
      mhead[i] = (mhead[i] + 1) % MAXD;
      mcnt[i]--;
      return d;
   endfunction

   function automatic int m_total(int k, int c);
      int i = k * NC + c;
      return mcnt[i] + ((P_REG[k] != 0 && mov[i]) ? 1 : 0);
   endfunction

   // Apply one clock edge to the model using the inputs held across it.
   function automatic void model_step();
      for (int k = 0; k < NI; k++) begin
         for (int c = 0; c < NC; c++) begin
            int i = k * NC + c;
            bit wr, pop, had;
            logic [7:0] dummy;
            if (rst || fl[c]) begin
               mcnt[i] = 0; mhead[i] = 0; mov[i] = 1'b0;
               continue;
            end
            wr = iv[c] && (m_total(k, c) < P_DEPTH[k]);
            if (P_REG[k] == 0) begin
               pop = ordy[c] && (mcnt[i] > 0);
               if (pop) dummy = q_pop(i);
            end else begin
               pop = ordy[c] && mov[i];
               had = (mcnt[i] > 0);
               if (pop) mov[i] = 1'b0;
               if (!mov[i] && had) begin
                  mod[i] = q_pop(i);
                  mov[i] = 1'b1;
               end
            end
            if (wr) q_push(i, idata[c*8 +: 8]);
         end
      end
   endfunction

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic get_obs(input int k, input int c,
                          output logic [31:0] rdy, output logic [31:0] vld,
                          output logic [31:0] dat, output logic [31:0] uw,
                          output logic [31:0] af, output logic [31:0] ae);
      case (k)
         0: begin
            rdy = 32'(ifa.input_ready[c]);        vld = 32'(ifa.output_valid[c]);
            dat = 32'(ifa.output_data[c*8 +: 8]); uw  = 32'(ifa.input_usedw[c*3 +: 3]);
            af  = 32'(ifa.input_almost_full[c]);  ae  = 32'(ifa.output_almost_empty[c]);
         end
         1: begin
            rdy = 32'(ifb.input_ready[c]);        vld = 32'(ifb.output_valid[c]);
            dat = 32'(ifb.output_data[c*8 +: 8]); uw  = 32'(ifb.input_usedw[c*3 +: 3]);
            af  = 32'(ifb.input_almost_full[c]);  ae  = 32'(ifb.output_almost_empty[c]);
         end
         2: begin
            rdy = 32'(ifc.input_ready[c]);        vld = 32'(ifc.output_valid[c]);
            dat = 32'(ifc.output_data[c*8 +: 8]); uw  = 32'(ifc.input_usedw[c*4 +: 4]);
            af  = 32'(ifc.input_almost_full[c]);  ae  = 32'(ifc.output_almost_empty[c]);
         end
         default: begin
            rdy = 32'(ifd.input_ready[c]);        vld = 32'(ifd.output_valid[c]);
            dat = 32'(ifd.output_data[c*8 +: 8]); uw  = 32'(ifd.input_usedw[c*2 +: 2]);
            af  = 32'(ifd.input_almost_full[c]);  ae  = 32'(ifd.output_almost_empty[c]);
         end
      endcase
   endtask

   task automatic compare_all();
      logic [31:0] rdy, vld, dat, uw, af, ae;
      for (int k = 0; k < NI; k++) begin
         for (int c = 0; c < NC; c++) begin
            int i     = k * NC + c;
            int total = m_total(k, c);
            bit ev    = (P_REG[k] != 0) ? mov[i] : (mcnt[i] > 0);
            get_obs(k, c, rdy, vld, dat, uw, af, ae);
            chk($sformatf("i%0d.c%0d.ready", k, c), rdy, 32'((!rst) && (total < P_DEPTH[k])));
            chk($sformatf("i%0d.c%0d.valid", k, c), vld, 32'(ev));
            chk($sformatf("i%0d.c%0d.usedw", k, c), uw, 32'(total));
            chk($sformatf("i%0d.c%0d.afull", k, c), af, 32'(total >= P_DEPTH[k] - P_AF[k]));
            chk($sformatf("i%0d.c%0d.aempty", k, c), ae, 32'(total <= P_AE[k]));
            if (ev) begin
               chk($sformatf("i%0d.c%0d.data", k, c), dat,
                   32'((P_REG[k] != 0) ? mod[i] : mbuf[i][mhead[i]]));
            end
         end
      end
   endtask

   // One clock: inputs already set; model follows the edge, outputs compared mid-cycle.
   task automatic cycle();
      @(posedge clk);
      model_step();
      cyc++;
      @(negedge clk);
      compare_all();
   endtask

   task automatic drive(input logic [1:0] v, input logic [15:0] d,
                        input logic [1:0] r, input logic [1:0] f);
      iv = v; idata = d; ordy = r; fl = f;
   endtask

   task automatic random_phase(input int n, input int pv, input int pr, input int pf);
      for (int t = 0; t < n; t++) begin
         for (int c = 0; c < NC; c++) begin
            iv[c]   = ($urandom_range(99) < pv);
            ordy[c] = ($urandom_range(99) < pr);
            fl[c]   = ($urandom_range(999) < pf);
         end
         idata = 16'($urandom);
         cycle();
      end
   endtask

   initial begin
      logic [31:0] rdy, vld, dat, uw, af, ae;
      for (int i = 0; i < NI*NC; i++) begin
         mhead[i] = 0; mcnt[i] = 0; mov[i] = 1'b0; mod[i] = '0;
      end
      rst = 1'b1;
      drive(2'b00, 16'h0, 2'b00, 2'b00);
      @(negedge clk);
      repeat (3) cycle();
      rst = 1'b0;
      cycle();
      $display("phase reset: usedw/valid/flags at reset values");

      // Fill ch0 with 1..6 while the reader stalls; the sixth must be refused.
      for (int n = 1; n <= 6; n++) begin
         drive(2'b01, 16'(n), 2'b00, 2'b00);
         cycle();
      end
      get_obs(0, 0, rdy, vld, dat, uw, af, ae);
      chk("fill_usedw", uw, 5);
      chk("fill_ready", rdy, 0);
      drive(2'b00, 16'h0, 2'b01, 2'b00);
      for (int n = 1; n <= 5; n++) begin
         get_obs(0, 0, rdy, vld, dat, uw, af, ae);
         chk("fill_pop_data", dat, 32'(n));
         cycle();
      end
      get_obs(0, 0, rdy, vld, dat, uw, af, ae);
      chk("fill_drained_valid", vld, 0);
      repeat (3) cycle();
      $display("phase fill: ch0 filled to depth and drained in order");

      // Latency into an empty channel.
      drive(2'b01, 16'h00A5, 2'b00, 2'b00);
      cycle();
      drive(2'b00, 16'h0, 2'b00, 2'b00);
      get_obs(0, 0, rdy, vld, dat, uw, af, ae);
      chk("lat_show_ahead_valid", vld, 1);
      chk("lat_show_ahead_data", dat, 32'h A5);
      get_obs(1, 0, rdy, vld, dat, uw, af, ae);
      chk("lat_reg_early_valid", vld, 0);
      cycle();
      get_obs(1, 0, rdy, vld, dat, uw, af, ae);
      chk("lat_reg_valid", vld, 1);
      chk("lat_reg_data", dat, 32'h A5);
      drive(2'b00, 16'h0, 2'b11, 2'b00);
      repeat (3) cycle();
      $display("phase latency: 0xA5 seen after 1 and 2 edges");

      // Continuous stream: both sides active every cycle, pointers wrap.
      for (int n = 0; n < 20; n++) begin
         drive(2'b11, {8'(8'h40 + n), 8'(n + 1)}, 2'b11, 2'b00);
         cycle();
      end
      get_obs(0, 0, rdy, vld, dat, uw, af, ae);
      chk("stream_usedw_show_ahead", uw, 1);
      get_obs(1, 0, rdy, vld, dat, uw, af, ae);
      chk("stream_usedw_reg", uw, 2);
      // Full plus pop must still reject the write.
      drive(2'b11, 16'h7733, 2'b00, 2'b00);
      repeat (6) cycle();
      drive(2'b11, 16'h5566, 2'b11, 2'b00);
      cycle();
      get_obs(0, 0, rdy, vld, dat, uw, af, ae);
      chk("fullpop_usedw", uw, 4);
      $display("phase stream: 20 values streamed, full+pop rejects write");

      // Flush ch1 holding 3 entries with a simultaneous write and pop.
      drive(2'b00, 16'h0, 2'b11, 2'b11);
      cycle();
      drive(2'b11, 16'h2211, 2'b00, 2'b00); cycle();
      drive(2'b11, 16'h4433, 2'b00, 2'b00); cycle();
      drive(2'b10, 16'h6655, 2'b00, 2'b00); cycle();
      drive(2'b10, 16'h8877, 2'b10, 2'b10);
      cycle();
      drive(2'b00, 16'h0, 2'b00, 2'b00);
      get_obs(0, 1, rdy, vld, dat, uw, af, ae);
      chk("flush_c1_usedw", uw, 0);
      chk("flush_c1_valid", vld, 0);
      chk("flush_c1_aempty", ae, 1);
      get_obs(0, 0, rdy, vld, dat, uw, af, ae);
      chk("flush_c0_usedw", uw, 2);
      chk("flush_c0_data", dat, 32'h11);
      // Flush held high: writes dropped, ready stays up.
      drive(2'b11, 16'h9999, 2'b00, 2'b11);
      repeat (2) cycle();
      $display("phase flush: ch1 emptied, ch0 untouched");

      // Thresholds on inst 2 (DEPTH=8, AF=2, AE=1).
      drive(2'b00, 16'h0, 2'b00, 2'b00);
      cycle();
      get_obs(2, 0, rdy, vld, dat, uw, af, ae);
      chk("thr_empty_aempty", ae, 1);
      for (int n = 1; n <= 6; n++) begin
         drive(2'b01, 16'(n), 2'b00, 2'b00);
         cycle();
         get_obs(2, 0, rdy, vld, dat, uw, af, ae);
         if (n == 1) chk("thr_u1_aempty", ae, 1);
         if (n == 2) chk("thr_u2_aempty", ae, 0);
         if (n == 5) chk("thr_u5_afull", af, 0);
         if (n == 6) chk("thr_u6_afull", af, 1);
      end
      $display("phase thresholds: flags follow usedw one edge later");

      random_phase(300, 50, 50, 15);
      random_phase(300, 85, 25, 5);
      random_phase(300, 25, 85, 5);
      $display("phase random: 900 randomized cycles");

      // Reset mid-stream with contents present.
      drive(2'b11, 16'h0C0B, 2'b00, 2'b00);
      repeat (4) cycle();
      rst = 1'b1;
      drive(2'b11, 16'hEEEE, 2'b11, 2'b00);
      repeat (2) cycle();
      rst = 1'b0;
      drive(2'b00, 16'h0, 2'b00, 2'b00);
      cycle();
      get_obs(0, 0, rdy, vld, dat, uw, af, ae);
      chk("rst_mid_ready", rdy, 1);
      chk("rst_mid_valid", vld, 0);
      drive(2'b01, 16'h003C, 2'b00, 2'b00);
      cycle();
      drive(2'b00, 16'h0, 2'b01, 2'b00);
      get_obs(0, 0, rdy, vld, dat, uw, af, ae);
      chk("rst_mid_new_data", dat, 32'h3C);
      repeat (3) cycle();
      $display("phase reset-mid: old contents discarded");

      random_phase(400, 60, 60, 10);
      $display("phase random2: 400 randomized cycles");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Hard stop in case the stimulus sequence ever stalls.
   initial begin
      #500000;
      $display("FAIL timeout: observed cycle %0d expected completion", cyc);
      $fatal(1, "bench timeout");
   end

endmodule
